// File: rtl/uart_pkg.sv
// Shared definitions for the UART network interface: frame geometry and FSM state encodings.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; dout reads 0 while empty.
// A push into a full FIFO is accepted only when a pop retires an entry on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // NOTE: storage has no reset; empty/count gate every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_nic.sv
// Byte-wide UART NIC: TX FIFO feeding an 8N1 serializer, 8N1 deserializer feeding an RX FIFO.
// Single clock domain; rx is synchronised by two flops before the receive FSM.
module uart_nic
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rx_valid,
    output logic       tx_full,
    output logic       tx_busy,
    output logic       rx_overrun,
    output logic       frame_err,
    input  logic       rx,
    output logic       tx
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

    // ---------------------------------------------------------------- TX path
    uart_state_e    tx_state, tx_state_next;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_next;
    logic [2:0]     tx_bit, tx_bit_next;
    logic [7:0]     tx_shift, tx_shift_next;
    logic           tx_q, tx_next;
    logic           tx_pop;
    logic           tx_empty;
    logic [7:0]     tx_head;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_en),
        .din   (wr_data),
        .pop   (tx_pop),
        .dout  (tx_head),
        .empty (tx_empty),
        .full  (tx_full)
    );

    // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
    always_comb begin
        tx_state_next = tx_state;
        tx_cnt_next   = tx_cnt + CNT_ONE;
        tx_bit_next   = tx_bit;
        tx_shift_next = tx_shift;
        tx_next       = tx_q;
        tx_pop        = 1'b0;
        case (tx_state)
            ST_IDLE: begin
                tx_cnt_next = '0;
                if (!tx_empty) begin
                    tx_pop        = 1'b1;
                    tx_shift_next = tx_head;
                    tx_next       = 1'b0;
                    tx_state_next = ST_START;
                end
            end
            ST_START: begin
                if (tx_cnt == CNT_LAST) begin
                    tx_cnt_next   = '0;
                    tx_bit_next   = '0;
                    tx_next       = tx_shift[0];
                    tx_shift_next = tx_shift >> 1;
                    tx_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tx_cnt == CNT_LAST) begin
                    tx_cnt_next = '0;
                    if (tx_bit == BIT_LAST) begin
                        tx_next       = 1'b1;
                        tx_state_next = ST_STOP;
                    end else begin
                        tx_bit_next   = tx_bit + 3'd1;
                        tx_next       = tx_shift[0];
                        tx_shift_next = tx_shift >> 1;
                    end
                end
            end
            ST_STOP: begin
                if (tx_cnt == CNT_LAST) begin
                    tx_cnt_next = '0;
                    // Chain straight into the next start bit so queued bytes leave without an idle gap.
                    if (!tx_empty) begin
                        tx_pop        = 1'b1;
                        tx_shift_next = tx_head;
                        tx_next       = 1'b0;
                        tx_state_next = ST_START;
                    end else begin
                        tx_state_next = ST_IDLE;
                    end
                end
            end
            default: tx_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_q     <= 1'b1;
        end else begin
            tx_state <= tx_state_next;
            tx_cnt   <= tx_cnt_next;
            tx_bit   <= tx_bit_next;
            tx_shift <= tx_shift_next;
            tx_q     <= tx_next;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = (tx_state != ST_IDLE) || !tx_empty;

    // ---------------------------------------------------------------- RX path
    uart_state_e    rx_state, rx_state_next;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_next;
    logic [2:0]     rx_bit, rx_bit_next;
    logic [7:0]     rx_shift, rx_shift_next;
    logic           rx_meta, rx_sync;
    logic           rx_push;
    logic           frame_err_next;
    logic           rx_empty;
    logic           rx_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    always_comb begin
        rx_state_next  = rx_state;
        rx_cnt_next    = rx_cnt + CNT_ONE;
        rx_bit_next    = rx_bit;
        rx_shift_next  = rx_shift;
        rx_push        = 1'b0;
        frame_err_next = 1'b0;
        case (rx_state)
            ST_IDLE: begin
                rx_cnt_next = '0;
                if (!rx_sync) begin
                    rx_state_next = ST_START;
                end
            end
            ST_START: begin
                // Re-check mid start bit; a line already back high was only a glitch.
                if (rx_cnt == CNT_HALF) begin
                    rx_cnt_next   = '0;
                    rx_bit_next   = '0;
                    rx_state_next = rx_sync ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_cnt == CNT_LAST) begin
                    rx_cnt_next   = '0;
                    rx_shift_next = {rx_sync, rx_shift[7:1]};
                    if (rx_bit == BIT_LAST) begin
                        rx_state_next = ST_STOP;
                    end else begin
                        rx_bit_next = rx_bit + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (rx_cnt == CNT_LAST) begin
                    rx_cnt_next    = '0;
                    rx_push        = rx_sync;
                    frame_err_next = !rx_sync;
                    rx_state_next  = ST_IDLE;
                end
            end
            default: rx_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state   <= ST_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            frame_err  <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_state  <= rx_state_next;
            rx_cnt    <= rx_cnt_next;
            rx_bit    <= rx_bit_next;
            rx_shift  <= rx_shift_next;
            frame_err <= frame_err_next;
            // A full FIFO still takes the byte when the OS pops on the same edge.
            if (rx_push && rx_full && !rd_en) begin
                rx_overrun <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (rx_shift),
        .pop   (rd_en),
        .dout  (rd_data),
        .empty (rx_empty),
        .full  (rx_full)
    );

    assign rx_valid = !rx_empty;

endmodule

// File: tb/tb_uart_nic.sv
// Directed self-checking bench for uart_nic with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
module tb_uart_nic;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       rx_valid;
    logic       tx_full;
    logic       tx_busy;
    logic       rx_overrun;
    logic       frame_err;
    logic       rx;
    logic       tx;
    logic       rx_drv = 1'b1;
    logic       loopback = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    assign rx = loopback ? tx : rx_drv;

    uart_nic #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rx_valid   (rx_valid),
        .tx_full    (tx_full),
        .tx_busy    (tx_busy),
        .rx_overrun (rx_overrun),
        .frame_err  (frame_err),
        .rx         (rx),
        .tx         (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Independent serial decoder: finds a start bit on tx and samples each bit late in its cell.
    task automatic recv_tx(output logic [7:0] b, output int start_cyc, output bit ok);
        ok = 1'b0;
        b = 8'h00;
        start_cyc = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) return;
        start_cyc = cyc;
        repeat (2) @(negedge clk);
        if (tx !== 1'b0) ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
            repeat (CPB) @(negedge clk);
            b[k] = tx;
        end
        repeat (CPB) @(negedge clk);
        if (tx !== 1'b1) ok = 1'b0;
    endtask

    // Drives one 8N1 frame on rx; must be called at a falling edge. Leaves rx at the stop level.
    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        rx_drv = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx_drv = b[k];
            repeat (CPB) @(negedge clk);
        end
        rx_drv = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic wait_rx_valid(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rx_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [13:0] obs;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        obs = {tx, rx_valid, tx_full, tx_busy, rx_overrun, frame_err, rd_data};
        n_checks++;
        if (obs !== 14'b1_00000_00000000) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected %b", obs, 14'b1_00000_00000000);
        end
        rst = 1'b0;
        @(negedge clk);
        obs = {tx, rx_valid, tx_full, tx_busy, rx_overrun, frame_err, rd_data};
        n_checks++;
        if (obs !== 14'b1_00000_00000000) begin
            n_fail++;
            $display("FAIL reset_release: got %b expected %b", obs, 14'b1_00000_00000000);
        end
    endtask

    task automatic test_single_tx();
        logic [9:0] exp_bits;
        exp_bits = {1'b1, 8'hA5, 1'b0};
        @(negedge clk);
        wr_en = 1'b1;
        wr_data = 8'hA5;
        @(negedge clk);
        wr_en = 1'b0;
        n_checks++;
        if ({tx, tx_busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL single_tx_latency: got tx/busy %b expected 11", {tx, tx_busy});
        end
        for (int j = 0; j < 10; j++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                n_checks++;
                if (tx !== exp_bits[j]) begin
                    n_fail++;
                    $display("FAIL single_tx_bit%0d_clk%0d: got %b expected %b", j, c, tx, exp_bits[j]);
                end
            end
        end
        @(negedge clk);
        n_checks++;
        if ({tx, tx_busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL single_tx_done: got tx/busy %b expected 10", {tx, tx_busy});
        end
    endtask

    // Pushes 0x01..0x06 on consecutive edges. 0x01 is popped on the edge that takes 0x02, so 0x05
    // lands with three entries queued and is accepted; 0x06 meets a full FIFO with no pop and is dropped.
    task automatic test_tx_overflow();
        logic [7:0] got [5];
        int         st  [5];
        bit         okv [5];
        bit         extra;
        fork
            begin
                @(negedge clk);
                wr_en = 1'b1;
                for (int d = 1; d <= 6; d++) begin
                    if (d == 5) begin
                        n_checks++;
                        if (tx_full !== 1'b0) begin
                            n_fail++;
                            $display("FAIL tx_full_before_5: got %b expected 0", tx_full);
                        end
                    end
                    wr_data = 8'(d);
                    @(negedge clk);
                end
                wr_en = 1'b0;
                n_checks++;
                if (tx_full !== 1'b1) begin
                    n_fail++;
                    $display("FAIL tx_full_after_6: got %b expected 1", tx_full);
                end
            end
            begin
                for (int i = 0; i < 5; i++) recv_tx(got[i], st[i], okv[i]);
            end
        join
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (!okv[i] || got[i] !== 8'(i + 1)) begin
                n_fail++;
                $display("FAIL tx_overflow_byte%0d: got %h (framed %0d) expected %h", i, got[i], okv[i], 8'(i + 1));
            end
            if (i > 0) begin
                n_checks++;
                if (st[i] - st[i-1] != FRAME) begin
                    n_fail++;
                    $display("FAIL back_to_back_gap%0d: got %0d cycles expected %0d", i, st[i] - st[i-1], FRAME);
                end
            end
        end
        extra = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx === 1'b0) extra = 1'b1;
        end
        n_checks++;
        if ({extra, tx_busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL tx_overflow_drop6: got extra/busy %b expected 00", {extra, tx_busy});
        end
    endtask

    task automatic test_rx_loopback();
        bit seen;
        loopback = 1'b1;
        @(negedge clk);
        wr_en = 1'b1;
        wr_data = 8'h3C;
        @(negedge clk);
        wr_en = 1'b0;
        wait_rx_valid(seen);
        n_checks++;
        if (!seen || rd_data !== 8'h3C) begin
            n_fail++;
            $display("FAIL loopback_3c: got valid %0d data %h expected 1 3c", seen, rd_data);
        end
        rd_en = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({rx_valid, rd_data} !== 9'h000) begin
            n_fail++;
            $display("FAIL loopback_pop1: got %h expected 000", {rx_valid, rd_data});
        end
        @(negedge clk);
        rd_en = 1'b0;
        n_checks++;
        if ({rx_valid, rd_data} !== 9'h000) begin
            n_fail++;
            $display("FAIL loopback_pop_empty: got %h expected 000", {rx_valid, rd_data});
        end
        wr_en = 1'b1;
        wr_data = 8'h5A;
        @(negedge clk);
        wr_en = 1'b0;
        wait_rx_valid(seen);
        n_checks++;
        if (!seen || rd_data !== 8'h5A) begin
            n_fail++;
            $display("FAIL loopback_5a: got valid %0d data %h expected 1 5a", seen, rd_data);
        end
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        n_checks++;
        if (rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL loopback_final_empty: got %b expected 0", rx_valid);
        end
        repeat (20) @(negedge clk);
        loopback = 1'b0;
    endtask

    task automatic test_rx_overrun();
        @(negedge clk);
        for (int i = 0; i < 4; i++) send_rx(8'(16 + i), 1'b1);
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rx_overrun, rx_valid, rd_data} !== {2'b01, 8'h10}) begin
            n_fail++;
            $display("FAIL overrun_after4: got %h expected %h", {rx_overrun, rx_valid, rd_data}, {2'b01, 8'h10});
        end
        send_rx(8'h14, 1'b1);
        repeat (3) @(negedge clk);
        n_checks++;
        if (rx_overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_after5: got %b expected 1", rx_overrun);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({rx_valid, rd_data} !== {1'b1, 8'(16 + i)}) begin
                n_fail++;
                $display("FAIL overrun_content%0d: got %h expected %h", i, {rx_valid, rd_data}, {1'b1, 8'(16 + i)});
            end
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
        end
        n_checks++;
        if ({rx_valid, rx_overrun} !== 2'b01) begin
            n_fail++;
            $display("FAIL overrun_drained: got valid/overrun %b expected 01", {rx_valid, rx_overrun});
        end
    endtask

    task automatic test_framing();
        int fe_cnt;
        int v_cnt;
        fe_cnt = 0;
        v_cnt  = 0;
        @(negedge clk);
        fork
            begin
                send_rx(8'h55, 1'b0);
                rx_drv = 1'b1;
            end
            begin
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    fe_cnt += int'(frame_err);
                    v_cnt  += int'(rx_valid);
                end
            end
        join
        n_checks++;
        if (fe_cnt != 1 || v_cnt != 0) begin
            n_fail++;
            $display("FAIL frame_err_pulse: got err cycles %0d valid cycles %0d expected 1 0", fe_cnt, v_cnt);
        end
        fe_cnt = 0;
        v_cnt  = 0;
        rx_drv = 1'b0;
        @(negedge clk);
        rx_drv = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            fe_cnt += int'(frame_err);
            v_cnt  += int'(rx_valid);
        end
        n_checks++;
        if (fe_cnt != 0 || v_cnt != 0) begin
            n_fail++;
            $display("FAIL glitch_ignored: got err cycles %0d valid cycles %0d expected 0 0", fe_cnt, v_cnt);
        end
        send_rx(8'hA7, 1'b1);
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rx_valid, rd_data} !== {1'b1, 8'hA7}) begin
            n_fail++;
            $display("FAIL post_glitch_frame: got %h expected %h", {rx_valid, rd_data}, {1'b1, 8'hA7});
        end
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        int         st;
        bit         ok;
        bit         extra;
        send_rx(8'h42, 1'b1);
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rx_valid, rd_data} !== {1'b1, 8'h42}) begin
            n_fail++;
            $display("FAIL midreset_rx_preload: got %h expected %h", {rx_valid, rd_data}, {1'b1, 8'h42});
        end
        wr_en = 1'b1;
        wr_data = 8'hFF;
        @(negedge clk);
        wr_data = 8'h00;
        @(negedge clk);
        wr_en = 1'b0;
        // Now just after edge k+1 (start bit); data bit 3 occupies cycles after edges k+17..k+20.
        repeat (17) @(negedge clk);
        n_checks++;
        if ({tx, tx_busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL midreset_before: got tx/busy %b expected 11", {tx, tx_busy});
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({tx, tx_busy, tx_full, rx_valid, rd_data} !== {4'b1000, 8'h00}) begin
            n_fail++;
            $display("FAIL midreset_async: got %h expected %h", {tx, tx_busy, tx_full, rx_valid, rd_data}, {4'b1000, 8'h00});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        fork
            begin
                wr_en = 1'b1;
                wr_data = 8'h81;
                @(negedge clk);
                wr_en = 1'b0;
            end
            recv_tx(b, st, ok);
        join
        n_checks++;
        if (!ok || b !== 8'h81) begin
            n_fail++;
            $display("FAIL midreset_next_byte: got %h (framed %0d) expected 81", b, ok);
        end
        extra = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx === 1'b0) extra = 1'b1;
        end
        n_checks++;
        if ({extra, tx_busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL midreset_fifo_cleared: got extra/busy %b expected 00", {extra, tx_busy});
        end
    endtask

    initial begin
        test_reset();
        test_single_tx();
        test_tx_overflow();
        test_rx_loopback();
        test_rx_overrun();
        test_framing();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
